// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-slave RAM block.
// Holds the frame-decoder state encoding and the 2-bit command codes
// that the first two bits of every frame select between.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_array.sv
// DATA_WIDTH x MEM_DEPTH storage with one synchronous write port and one
// synchronous read port. No reset: contents survive rst_n.
// Addresses at or above MEM_DEPTH are out of range: writes there are
// dropped and reads return all zeros.
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, registered into rdata every cycle
//   rdata  out  registered read data
module spi_ram_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
    rdata <= raddr_ok ? mem[raddr] : '0;
  end

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave in front of a word RAM. Each frame (SS_n low) starts with a
// 2-bit command: set write pointer, burst-write data, set read pointer or
// burst-read data. The system clock is also the shift clock; MOSI is
// sampled and MISO is updated on every rising edge.
//   clk    in   system/shift clock
//   rst_n  in   asynchronous active-low reset
//   SS_n   in   slave select, active low, frame delimiter
//   MOSI   in   serial data in, MSB first
//   MISO   out  serial data out, MSB first (registered)
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CW-1:0]         A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         A_DONE = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0]         D_LAST = CW'(DATA_WIDTH - 1);

  // Wrap on ">=" so a pointer parked out of range returns to 0 on its
  // next advance instead of creeping through unmapped addresses.
  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] p);
    if (AUTO_INC == 0) return p;
    return (p >= LAST) ? '0 : p + 1'b1;
  endfunction

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [SW-1:0]         sh, sh_d;
  logic                  miso, miso_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_d;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [SW:0]           sh_in;

  assign sh_in = {sh, MOSI};
  assign MISO  = miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      miso   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sh     <= sh_d;
      miso   <= miso_d;
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sh_d     = sh;
    miso_d   = 1'b0;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    we       = 1'b0;
    wdata    = sh_in[DATA_WIDTH-1:0];

    if (SS_n) begin
      // Frame end or abort: partial shifts are discarded, pointers keep
      // their last committed values.
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
          sh_d    = SW'(MOSI);
        end
        CMD: begin
          cnt_d = '0;
          sh_d  = '0;
          case ({sh[0], MOSI})
            CMD_WR_ADDR: state_d = WR_ADDR;
            CMD_WR_DATA: state_d = WR_DATA;
            CMD_RD_ADDR: state_d = RD_ADDR;
            default: begin
              state_d = RD_DATA;
              // Preload so the first RD_DATA edge is the turnaround load.
              cnt_d   = D_LAST;
            end
          endcase
        end
        WR_ADDR, RD_ADDR: begin
          // cnt parks at A_DONE; extra bits in the frame are ignored.
          if (cnt != A_DONE) begin
            sh_d  = sh_in[SW-1:0];
            cnt_d = cnt + 1'b1;
            if (cnt == A_LAST) begin
              if (state == WR_ADDR) wr_ptr_d = sh_in[ADDR_WIDTH-1:0];
              else                  rd_ptr_d = sh_in[ADDR_WIDTH-1:0];
            end
          end
        end
        WR_DATA: begin
          if (cnt == D_LAST) begin
            we       = 1'b1;
            cnt_d    = '0;
            sh_d     = '0;
            wr_ptr_d = advance(wr_ptr);
          end else begin
            sh_d  = sh_in[SW-1:0];
            cnt_d = cnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (cnt == D_LAST) begin
            // Load next word: MSB goes straight to MISO, rest waits in sh.
            miso_d   = rd_data[DATA_WIDTH-1];
            sh_d     = SW'(rd_data) << 1;
            cnt_d    = '0;
            rd_ptr_d = advance(rd_ptr);
          end else begin
            miso_d = sh[DATA_WIDTH-1];
            sh_d   = sh << 1;
            cnt_d  = cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read port tracks the next pointer value so rd_data always holds
  // mem[rd_ptr] after each edge, even right after an advance.
  spi_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr_d),
    .rdata (rd_data)
  );

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI-slave-plus-RAM block and the successor of the fixed 10-bit-frame SPI/RAM wrapper. It decodes a 2-bit command followed by a payload whose width depends on the command. It supports configurable address width, data width and memory depth, plus auto-incrementing burst writes and burst reads for as long as SS_n stays low. It sits directly on the external SPI pins. The system clock doubles as the shift clock.

## Interface
- ADDR_WIDTH, 8: address payload width in bits.
- DATA_WIDTH, 8: data word width in bits.
- MEM_DEPTH, 256: number of words; must satisfy 1 ≤ MEM_DEPTH ≤ 2**ADDR_WIDTH.
- AUTO_INC, 1: 1 = pointer increments after each data word; 0 = pointer held.
- clk  in  1  system/shift clock; every action happens on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low; frame delimiter.
- MOSI  in  1  serial in, MSB first.
- MISO  out  1  serial out, MSB first.

## Operation
- Edge numbering: E0 is the first rising edge that samples SS_n=0 after SS_n=1 (or after reset). MOSI is sampled at every edge.
- Command: bits sampled at E0 and E1 form cmd[1:0], MSB first.
  - 00 = WR_ADDR.
  - 01 = WR_DATA.
  - 10 = RD_ADDR.
  - 11 = RD_DATA.
- WR_ADDR / RD_ADDR:
  - Edges E2..E(ADDR_WIDTH+1) shift in the address.
  - At the last of these edges, wr_ptr / rd_ptr is loaded.
  - Later bits in the same frame are ignored.
- WR_DATA (burst):
  - Each group of DATA_WIDTH edges starting at E2 forms one word.
  - On the last edge of a word, mem[wr_ptr] is written, then wr_ptr advances if AUTO_INC=1.
  - Bursting continues until SS_n rises.
- RD_DATA (burst):
  - E2 is a turnaround edge: the shifter loads mem[rd_ptr], and rd_ptr advances if AUTO_INC=1.
  - MISO presents the word MSB first, one bit per edge, starting after E2.
  - On the edge that shifts out the LSB, the next word is loaded, so there is no gap between words.
- Pointer advance: wraps from MEM_DEPTH-1 to 0.
- Out-of-range address (≥ MEM_DEPTH):
  - Writes are dropped.
  - Reads return all zeros.
  - The pointer still wraps correctly on the next advance.
- States:
  - IDLE --SS_n=0--> CMD.
  - CMD --after 2 bits--> WR_ADDR | WR_DATA | RD_ADDR | RD_DATA.
  - Any state --SS_n=1 sampled--> IDLE.
- Abort: SS_n sampled high mid-word discards the partial shift with no memory write. Pointers keep their last committed values.
- Memory contents are not reset. Pointers persist across frames.

## Timing
- Reset values: MISO=0, state=IDLE, wr_ptr=0, rd_ptr=0, bit counter=0, shifters=0.
- MISO is registered. It is 0 in every state except RD_DATA after E2, and goes to 0 at the edge sampling SS_n=1.
- Latency:
  - Write commit occurs at the edge sampling the word's LSB, so write-to-read is visible to any later frame.
  - First read bit appears one edge after the turnaround.
- Bit counter width: clog2(max(ADDR_WIDTH, DATA_WIDTH)+1). It resets per word and per frame.
- Pointer arithmetic: ADDR_WIDTH bits, explicit compare against MEM_DEPTH-1 for wrap (not natural overflow).
- Same-address read/write in one cycle is impossible: one frame, one direction.
- Reset asserted mid-frame: all registers return to reset values immediately. The next frame requires SS_n low after rst_n deasserts.

## Structure
- Package spi_ram_pkg: state enum (IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA) and the 2-bit command constants.
- Sub-module spi_ram_array:
  - Parametrised DATA_WIDTH × MEM_DEPTH array.
  - One synchronous write port and one synchronous read port, no reset.
  - Range check and zero-return performed inside.
- The top holds the FSM, counter, shifters, pointers and MISO register.

## Test plan
- Defaults. WR_ADDR 0x10; WR_DATA burst 0xA5, 0x3C, 0xFF (one frame); RD_ADDR 0x10; RD_DATA for 24 edges after turnaround -> MISO stream A5 3C FF, no gaps.
- WR_ADDR 0xFF; WR_DATA burst 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); read-back confirms.
- MEM_DEPTH=200. WR_ADDR 0xC7; WR_DATA burst 0x55, 0x66 -> mem[199]=0x55, mem[0]=0x66.
- MEM_DEPTH=200. RD_ADDR 0xD0; RD_DATA -> MISO 0x00.
- WR_DATA with SS_n raised after 5 of 8 data bits -> no write, wr_ptr unchanged, MISO 0, next frame decodes normally.
- rst_n pulsed low mid RD_DATA -> MISO 0 immediately, rd_ptr=0. AUTO_INC=0 burst read of 0x10 -> A5 A5.
